// File: rtl/data_mem_resp.sv
// Data memory with a fixed-latency request/response handshake (Stall while busy, Done pulse on completion).
// Optional DATA_MEM_RESP_ALIGN_CHECK_EN: odd byte addresses complete with Err instead of accessing the array.
module data_mem_resp #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [15:0] memAddr,
    input  logic [15:0] wrData,
    output logic [15:0] rdData,
    output logic        Stall,
    output logic        Done,
    output logic        Err
);
    // state | meaning
    // IDLE  | no request outstanding; a new request may be accepted
    // BUSY  | request captured, latency counter running, further requests ignored
    // DONE  | completion cycle (Done high); a new request may be accepted
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam int         WORDS    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
            $error("data_mem_resp: LATENCY must be in 1..15");
        end
    endgenerate

    stateT                 state, nextState;
    logic [3:0]            cnt, cntNext;
    logic                  accept, complete, bypass;
    logic                  inErr;
    logic                  reqRead, reqWrite, reqErr;
    logic [DEPTH_LOG2-1:0] reqIdx;
    logic [15:0]           reqData;
    logic                  opRead, opWrite, opErr;
    logic [DEPTH_LOG2-1:0] opIdx;
    logic [15:0]           opData;
    logic                  unusedAddrBits;
    logic [15:0]           mem [WORDS];

    assign unusedAddrBits = ^memAddr;

`ifdef DATA_MEM_RESP_ALIGN_CHECK_EN
    assign inErr = (memRead & memWrite) | memAddr[0];
`else
    assign inErr = memRead & memWrite;
`endif

    assign accept = (state != BUSY) && (memRead || memWrite);

    // With LATENCY = 1 the request completes on its own accept edge, so the live inputs are used directly.
    assign bypass  = (state != BUSY);
    assign opRead  = bypass ? memRead : reqRead;
    assign opWrite = bypass ? memWrite : reqWrite;
    assign opErr   = bypass ? inErr : reqErr;
    assign opIdx   = bypass ? memAddr[DEPTH_LOG2:1] : reqIdx;
    assign opData  = bypass ? wrData : reqData;

    always_comb begin
        nextState = state;
        cntNext   = cnt;
        complete  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        nextState = DONE;
                        cntNext   = 4'd0;
                        complete  = 1'b1;
                    end else begin
                        nextState = BUSY;
                        cntNext   = CNT_LOAD;
                    end
                end else begin
                    nextState = IDLE;
                    cntNext   = 4'd0;
                end
            end
            BUSY: begin
                cntNext = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    nextState = DONE;
                    cntNext   = 4'd0;
                    complete  = 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
                cntNext   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            reqRead  <= 1'b0;
            reqWrite <= 1'b0;
            reqErr   <= 1'b0;
            reqIdx   <= '0;
            reqData  <= 16'h0000;
            rdData   <= 16'h0000;
            Err      <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= cntNext;
            if (accept) begin
                reqRead  <= memRead;
                reqWrite <= memWrite;
                reqErr   <= inErr;
                reqIdx   <= memAddr[DEPTH_LOG2:1];
                reqData  <= wrData;
            end
            if (complete) begin
                Err <= opErr;
                if (opRead && !opErr) begin
                    rdData <= mem[opIdx];
                end
            end
        end
    end

    // Storage is deliberately not reset; rst_n only blocks a write while reset is held.
    always_ff @(posedge clk) begin
        if (complete && opWrite && !opErr && rst_n) begin
            mem[opIdx] <= opData;
        end
    end

    assign Stall = (state == BUSY);
    assign Done  = (state == DONE);

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one LATENCY=2 instance for the main scenarios,
// one LATENCY=1 instance for back-to-back completion.
module tb_data_mem_resp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead, memWrite;
    logic [15:0] memAddr, wrData;
    logic [15:0] rdData;
    logic        Stall, Done, Err;
    logic        memRead1, memWrite1;
    logic [15:0] memAddr1, wrData1;
    logic [15:0] rdData1;
    logic        Stall1, Done1, Err1;
    int          nTests = 0;
    int          nFail  = 0;

    always #5 clk = ~clk;

    data_mem_resp #(.LATENCY(2), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .memAddr(memAddr), .wrData(wrData), .rdData(rdData),
        .Stall(Stall), .Done(Done), .Err(Err)
    );

    data_mem_resp #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .memRead(memRead1), .memWrite(memWrite1),
        .memAddr(memAddr1), .wrData(wrData1), .rdData(rdData1),
        .Stall(Stall1), .Done(Done1), .Err(Err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for a single edge, scramble the inputs, then wait (bounded) for Done.
    task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, output int lat);
        memRead  = rd;
        memWrite = wr;
        memAddr  = a;
        wrData   = d;
        tick();
        memRead  = 1'b0;
        memWrite = 1'b0;
        memAddr  = 16'hFFFF;
        wrData   = 16'hDEAD;
        lat = 1;
        while (Done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        nTests++;
        if ({Stall, Done, Err, rdData} !== 19'h0) begin
            nFail++;
            $display("FAIL reset_outputs: got Stall=%b Done=%b Err=%b rdData=%h, want all zero",
                     Stall, Done, Err, rdData);
        end
        nTests++;
        if ({Stall1, Done1, Err1, rdData1} !== 19'h0) begin
            nFail++;
            $display("FAIL reset_outputs_lat1: got Stall=%b Done=%b Err=%b rdData=%h, want all zero",
                     Stall1, Done1, Err1, rdData1);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        memWrite = 1'b1;
        memRead  = 1'b0;
        memAddr  = 16'h0010;
        wrData   = 16'hBEEF;
        tick();
        memWrite = 1'b0;
        wrData   = 16'hFFFF;
        nTests++;
        if (Stall !== 1'b1 || Done !== 1'b0) begin
            nFail++;
            $display("FAIL write_cycle1: got Stall=%b Done=%b, want Stall=1 Done=0", Stall, Done);
        end
        tick();
        nTests++;
        if (Done !== 1'b1 || Stall !== 1'b0 || Err !== 1'b0 || rdData !== 16'h0000) begin
            nFail++;
            $display("FAIL write_done: got Done=%b Stall=%b Err=%b rdData=%h, want 1 0 0 0000",
                     Done, Stall, Err, rdData);
        end
        memRead = 1'b1;
        memAddr = 16'h0010;
        tick();
        memRead = 1'b0;
        memAddr = 16'h0000;
        nTests++;
        if (Stall !== 1'b1 || Done !== 1'b0) begin
            nFail++;
            $display("FAIL read_from_done_busy: got Stall=%b Done=%b, want 1 0", Stall, Done);
        end
        tick();
        nTests++;
        if (Done !== 1'b1 || rdData !== 16'hBEEF || Err !== 1'b0) begin
            nFail++;
            $display("FAIL read_beef: got Done=%b rdData=%h Err=%b, want 1 BEEF 0", Done, rdData, Err);
        end
        tick();
        nTests++;
        if (Done !== 1'b0 || Stall !== 1'b0 || rdData !== 16'hBEEF) begin
            nFail++;
            $display("FAIL idle_hold: got Done=%b Stall=%b rdData=%h, want 0 0 BEEF", Done, Stall, rdData);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        memWrite = 1'b1;
        memAddr  = 16'h0040;
        wrData   = 16'h1111;
        tick();
        memAddr  = 16'h0040;
        wrData   = 16'h2222;
        tick();
        memWrite = 1'b0;
        nTests++;
        if (Done !== 1'b1) begin
            nFail++;
            $display("FAIL busy_ignore_done: got Done=%b, want 1", Done);
        end
        tick();
        issue(1'b1, 1'b0, 16'h0040, 16'h0000, lat);
        nTests++;
        if (lat !== 2 || rdData !== 16'h1111) begin
            nFail++;
            $display("FAIL busy_ignore_data: got lat=%0d rdData=%h, want 2 1111", lat, rdData);
        end
    endtask

    task automatic test_error();
        int lat;
        issue(1'b0, 1'b1, 16'h0020, 16'hA5A5, lat);
        issue(1'b1, 1'b0, 16'h0010, 16'h0000, lat);
        issue(1'b1, 1'b1, 16'h0020, 16'h0F0F, lat);
        nTests++;
        if (lat !== 2 || Err !== 1'b1 || rdData !== 16'hBEEF) begin
            nFail++;
            $display("FAIL rdwr_error: got lat=%0d Err=%b rdData=%h, want 2 1 BEEF", lat, Err, rdData);
        end
        tick();
        nTests++;
        if (Err !== 1'b1 || Done !== 1'b0) begin
            nFail++;
            $display("FAIL err_hold: got Err=%b Done=%b, want 1 0", Err, Done);
        end
        issue(1'b1, 1'b0, 16'h0020, 16'h0000, lat);
        nTests++;
        if (rdData !== 16'hA5A5 || Err !== 1'b0) begin
            nFail++;
            $display("FAIL rdwr_no_write: got rdData=%h Err=%b, want A5A5 0", rdData, Err);
        end
    endtask

    task automatic test_align();
        int lat;
        issue(1'b1, 1'b0, 16'h0011, 16'h0000, lat);
`ifdef DATA_MEM_RESP_ALIGN_CHECK_EN
        nTests++;
        if (Err !== 1'b1 || rdData !== 16'hA5A5) begin
            nFail++;
            $display("FAIL odd_addr: got Err=%b rdData=%h, want 1 A5A5", Err, rdData);
        end
`else
        nTests++;
        if (Err !== 1'b0 || rdData !== 16'hBEEF) begin
            nFail++;
            $display("FAIL odd_addr: got Err=%b rdData=%h, want 0 BEEF", Err, rdData);
        end
`endif
    endtask

    task automatic test_wrap();
        int lat;
        issue(1'b0, 1'b1, 16'h0202, 16'h7777, lat);
        issue(1'b1, 1'b0, 16'h0002, 16'h0000, lat);
        nTests++;
        if (rdData !== 16'h7777 || Err !== 1'b0) begin
            nFail++;
            $display("FAIL addr_wrap: got rdData=%h Err=%b, want 7777 0", rdData, Err);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int doneSeen;
        issue(1'b0, 1'b1, 16'h0030, 16'h5555, lat);
        tick();
        memWrite = 1'b1;
        memAddr  = 16'h0030;
        wrData   = 16'h1234;
        tick();
        memWrite = 1'b0;
        nTests++;
        if (Stall !== 1'b1) begin
            nFail++;
            $display("FAIL mid_busy: got Stall=%b, want 1", Stall);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nTests++;
        if ({Stall, Done, Err, rdData} !== 19'h0) begin
            nFail++;
            $display("FAIL mid_reset_outputs: got Stall=%b Done=%b Err=%b rdData=%h, want all zero",
                     Stall, Done, Err, rdData);
        end
        #2;
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Done === 1'b1) doneSeen++;
        end
        nTests++;
        if (doneSeen !== 0) begin
            nFail++;
            $display("FAIL mid_reset_no_done: got %0d Done cycles, want 0", doneSeen);
        end
        issue(1'b1, 1'b0, 16'h0030, 16'h0000, lat);
        nTests++;
        if (rdData !== 16'h5555) begin
            nFail++;
            $display("FAIL mid_reset_no_write: got rdData=%h, want 5555", rdData);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] expRd;
    } vecT;

    task automatic test_back_to_back();
        vecT v[7];
        v[0] = '{1'b0, 1'b1, 16'h0000, 16'h1001, 16'h0000};
        v[1] = '{1'b0, 1'b1, 16'h0002, 16'h2002, 16'h0000};
        v[2] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2002};
        v[3] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1001};
        v[4] = '{1'b0, 1'b1, 16'h0004, 16'h3003, 16'h1001};
        v[5] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h3003};
        v[6] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2002};
        for (int i = 0; i < 7; i++) begin
            memRead1  = v[i].rd;
            memWrite1 = v[i].wr;
            memAddr1  = v[i].addr;
            wrData1   = v[i].data;
            tick();
            nTests++;
            if (Done1 !== 1'b1 || Stall1 !== 1'b0 || Err1 !== 1'b0 || rdData1 !== v[i].expRd) begin
                nFail++;
                $display("FAIL b2b[%0d]: got Done=%b Stall=%b Err=%b rdData=%h, want 1 0 0 %h",
                         i, Done1, Stall1, Err1, rdData1, v[i].expRd);
            end
        end
        memRead1  = 1'b0;
        memWrite1 = 1'b0;
        tick();
        nTests++;
        if (Done1 !== 1'b0 || rdData1 !== 16'h2002) begin
            nFail++;
            $display("FAIL b2b_idle: got Done=%b rdData=%h, want 0 2002", Done1, rdData1);
        end
    endtask

    initial begin
        memRead   = 1'b0;
        memWrite  = 1'b0;
        memAddr   = 16'h0000;
        wrData    = 16'h0000;
        memRead1  = 1'b0;
        memWrite1 = 1'b0;
        memAddr1  = 16'h0000;
        wrData1   = 16'h0000;
        test_reset();
        test_write_read();
        test_ignore_busy();
        test_error();
        test_align();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from request acceptance to Done; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, log2 of the number of 16-bit words stored.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port memRead, input, 1, read request.
REQ-006 SHALL have port memWrite, input, 1, write request.
REQ-007 SHALL have port memAddr, input, 16, byte address from the execute-stage ALU.
REQ-008 SHALL have port wrData, input, 16, store data.
REQ-009 SHALL have port rdData, output, 16, load data, valid while Done is high.
REQ-010 SHALL have port Stall, output, 1, high while a request is in flight and not yet complete.
REQ-011 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port Err, output, 1, error flag qualified by Done.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 SHALL accept a request at a rising edge when the state is IDLE or DONE and (memRead | memWrite) = 1.
REQ-015 SHALL capture memRead, memWrite, memAddr and wrData at acceptance; later input changes SHALL NOT affect that request.
REQ-016 SHALL ignore request inputs while in BUSY; no queuing.
REQ-017 SHALL go to DONE on acceptance if LATENCY = 1; otherwise go to BUSY with a down-counter loaded with LATENCY-1.
REQ-018 SHALL decrement the counter each edge in BUSY and move to DONE on the edge where the counter reaches 0; Done is therefore high exactly LATENCY cycles after the accept edge.
REQ-019 SHALL go from DONE to IDLE on the next edge unless a new request is accepted, which enters BUSY or DONE per REQ-017.
REQ-020 SHALL drive Stall = 1 in BUSY only, and Done = 1 in DONE only, both decoded from registered state.
REQ-021 SHALL use word index memAddr[DEPTH_LOG2:1]; higher address bits ignored (wrap-around modulo 2^DEPTH_LOG2 words).
REQ-022 SHALL perform a write on the edge entering DONE; a read SHALL register array data into rdData on that same edge.
REQ-023 SHALL return the newly written value for a read accepted in the DONE cycle of a write to the same address.
REQ-024 SHALL hold rdData after a write or error completion at its previous value, and between completions at its last value.
REQ-025 SHALL treat memRead & memWrite both high as an error: Err = 1 at Done, no write, rdData unchanged.
REQ-026 SHALL register Err at the DONE-entry edge and hold it until the next completion.

Reset
REQ-027 SHALL, when rst_n is low, immediately force state IDLE, counter 0, rdData 0x0000, Err 0, Stall 0, Done 0.
REQ-028 SHALL, on reset mid-operation, drop the outstanding request; no array write occurs.
REQ-029 SHALL NOT reset the storage array contents.

Configuration
REQ-030 SHALL define macro DATA_MEM_RESP_ALIGN_CHECK_EN; when defined, an accepted request with memAddr[0] = 1 completes with Err = 1, no write, rdData unchanged.
REQ-031 SHALL, without DATA_MEM_RESP_ALIGN_CHECK_EN, ignore memAddr[0] and set Err only per REQ-025.

Verification
REQ-032 With LATENCY = 2, write 0xBEEF to 0x0010 at edge 0 -> Stall high cycle 1, Done high cycle 2, Err 0, Stall low.
REQ-033 Read 0x0010 accepted in that DONE cycle -> Done two cycles later with rdData = 0xBEEF.
REQ-034 Assert memRead and memWrite together at 0x0020 -> Done with Err = 1; a subsequent read of 0x0020 returns the prior contents.
REQ-035 With the macro defined, read at 0x0011 -> Done with Err = 1 and rdData unchanged. Without the macro, the same read returns word 0x0010 with Err = 0.
REQ-036 Pulse rst_n low during BUSY of a write of 0x1234 to 0x0030 -> outputs zero immediately, no Done. A later read of 0x0030 does not return 0x1234.
REQ-037 With LATENCY = 1, issue back-to-back reads each cycle -> Done high every cycle and Stall never high.
